unified_mem_responder: RTL
==========================

# unified_mem_responder

Single-port, byte-addressable memory responder that is the target end of the core's instruction-fetch and load/store request paths. It arbitrates one fetch port and one data port onto a single word array, performs byte-lane writes and sign/zero-extended loads, and returns registered responses with an error flag. After every reset it clears the whole array before accepting any request.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; must be a power of two no larger than 2^(ADDR_W-2).
- ADDR_W, 12: byte-address width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_req_valid  in  1  fetch request; always a 32-bit word read.
- if_req_ready  out  1  fetch request accepted this cycle when high together with valid.
- if_addr  in  ADDR_W  fetch byte address.
- if_rsp_valid  out  1  one-cycle pulse: fetch response.
- if_rdata  out  32  fetch data.
- if_rsp_err  out  1  fetch error (misaligned or out of range).
- d_req_valid  in  1  data request.
- d_req_ready  out  1  data request accepted when high together with valid.
- d_we  in  1  1 = store, 0 = load.
- d_funct3  in  3  access size/sign, RV32I funct3 encoding.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  32  store data, right-aligned.
- d_rsp_valid  out  1  one-cycle pulse: data response.
- d_rdata  out  32  load result, extended to 32 bits; 0 for stores.
- d_rsp_err  out  1  data error.
- init_done  out  1  high once clearing has finished.

## Operation
- FSM states: INIT, RUN.
- INIT: entered on rst; counter walks word 0..DEPTH_WORDS-1, writing 0 one word per cycle; both readies low. Leaves for RUN after the write of the last word. init_done goes high on the first RUN cycle.
- RUN: d_req_ready = 1; if_req_ready = ~d_req_valid (data has fixed priority; the single port serves one access per cycle).
- Loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; lanes are selected by addr[1:0]. Stores: 000 SB, 001 SH, 010 SW; only the addressed byte lanes are written.
- Undefined funct3 (011, 110, 111, and 1xx on a store): err.
- Misaligned: halfword with addr[0] = 1, or word with addr[1:0] != 0: err.
- Out of range: addr[ADDR_W-1:2] >= DEPTH_WORDS: err.
- An erring request is still accepted and answered. It does no write, and its rdata is 0.
- Stores are answered with rsp_valid = 1 and rdata = 0.
- Responses cannot be back-pressured; requesters must take them.

## Timing
- Request accepted at edge N: response on that port is valid for exactly the cycle after edge N, then deasserted.
- Stores commit at edge N. A load or fetch of the same word accepted at edge N+1 returns the new value (no bypass is needed).
- Back-to-back accepts are allowed on every cycle; throughput is one access per cycle across both ports.
- Simultaneous valid requests: the data request is accepted and the fetch waits. A fetch requester must hold valid and addr stable until ready.
- Reset values: if_req_ready = 0, d_req_ready = 0, if_rsp_valid = 0, d_rsp_valid = 0, both rdata = 0, both err = 0, init_done = 0, FSM = INIT, counter = 0.
- rst asserted mid-INIT restarts clearing from word 0.
- rst asserted in RUN drops any pending response, with no rsp_valid on the following cycle.
- INIT lasts exactly DEPTH_WORDS cycles after rst is released.

## Structure
- Shared package: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the FSM state enum, both reused by the core's load/store path.
- Sub-module mem_lane_align: combinational load extraction/extension plus store byte-enable and lane-replication generation, with the err decode. The top level holds the FSM, the arbiter, the array and the response registers.

## Test plan
- Reset release with DEPTH_WORDS = 16 -> readies are 0 for 16 cycles, then init_done = 1; a fetch of 0x000 returns 0x00000000 with err = 0.
- SW 0x8000_FF7F at 0x010, then LB, LBU, LH and LHU at 0x010 and 0x012 -> LB 0x010 = 0x0000007F; LB 0x011 = 0xFFFFFFFF; LBU 0x011 = 0x000000FF; LH 0x012 = 0xFFFF8000; LHU 0x012 = 0x00008000.
- SB 0xAA at 0x013 over 0x11223344 -> LW returns 0xAA223344.
- Fetch and data valid together for 3 cycles -> data is accepted each cycle, if_req_ready = 0 throughout, and the fetch is accepted on cycle 4 with its response on cycle 5.
- LW at 0x006, SH at 0x001, and LW at 0xFFC with DEPTH_WORDS = 16 -> err = 1 and rdata = 0 for each; memory is unchanged.
- rst pulsed while INIT is at word 5, and again in RUN with a load in flight -> clearing restarts at word 0; no d_rsp_valid is produced for the dropped load.

Source files
------------

// File: rtl/unified_mem_responder_pkg.sv
// Shared load/store encodings and responder FSM states.
// Reused by the core's load/store path so both ends agree on funct3 meaning.
package unified_mem_responder_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Byte lanes touched by an access of the given size at byte offset off.
   function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] m;
      case (f3[1:0])
         2'b00:   m = 4'b0001 << off;
         2'b01:   m = 4'b0011 << off;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/unified_mem_responder_if.sv
// Fetch and load/store request/response bundle between the core and the memory responder.
// The slave side is the responder; responses carry no ready and cannot be stalled.
interface unified_mem_responder_if #(
   parameter int ADDR_W = 12
);
   logic              if_req_valid;
   logic              if_req_ready;
   logic [ADDR_W-1:0] if_addr;
   logic              if_rsp_valid;
   logic [31:0]       if_rdata;
   logic              if_rsp_err;

   logic              d_req_valid;
   logic              d_req_ready;
   logic              d_we;
   logic [2:0]        d_funct3;
   logic [ADDR_W-1:0] d_addr;
   logic [31:0]       d_wdata;
   logic              d_rsp_valid;
   logic [31:0]       d_rdata;
   logic              d_rsp_err;

   logic              init_done;

   modport slave (
      input  if_req_valid, if_addr,
      output if_req_ready, if_rsp_valid, if_rdata, if_rsp_err,
      input  d_req_valid, d_we, d_funct3, d_addr, d_wdata,
      output d_req_ready, d_rsp_valid, d_rdata, d_rsp_err,
      output init_done
   );

   modport master (
      output if_req_valid, if_addr,
      input  if_req_ready, if_rsp_valid, if_rdata, if_rsp_err,
      output d_req_valid, d_we, d_funct3, d_addr, d_wdata,
      input  d_req_ready, d_rsp_valid, d_rdata, d_rsp_err,
      input  init_done
   );
endinterface

// File: rtl/unified_mem_responder_mem_lane_align.sv
// Combinational lane logic: error decode, store byte enables/replication, load extract/extend.
// No state; latency zero, no backpressure.
module mem_lane_align
   import unified_mem_responder_pkg::*;
(
   input  logic        i_we,
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_off,
   input  logic        i_in_range,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rword,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata,
   output logic        o_err
);

   logic        w_bad_f3;
   logic        w_misaligned;
   logic [31:0] w_shift;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_bad_f3     = 1'b0;
      w_misaligned = 1'b0;
      case (i_funct3)
         F3_B:    w_misaligned = 1'b0;
         F3_H:    w_misaligned = i_off[0];
         F3_W:    w_misaligned = |i_off;
         F3_BU:   w_bad_f3     = i_we;
         F3_HU: begin
            w_bad_f3     = i_we;
            w_misaligned = i_off[0];
         end
         default: w_bad_f3     = 1'b1;
      endcase
   end

   assign o_err = w_bad_f3 | w_misaligned | ~i_in_range;

   always_comb begin
      case (i_funct3[1:0])
         2'b00:   o_wdata = {4{i_wdata[7:0]}};
         2'b01:   o_wdata = {2{i_wdata[15:0]}};
         default: o_wdata = i_wdata;
      endcase
   end

   assign o_be = (i_we && !o_err) ? lane_mask(i_funct3, i_off) : 4'b0000;

   assign w_shift = i_rword >> {i_off, 3'b000};
   assign w_byte  = w_shift[7:0];
   assign w_half  = w_shift[15:0];

   always_comb begin
      o_rdata = 32'h0;
      if (!o_err && !i_we) begin
         case (i_funct3)
            F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
            F3_W:    o_rdata = i_rword;
            F3_BU:   o_rdata = {24'h0, w_byte};
            F3_HU:   o_rdata = {16'h0, w_half};
            default: o_rdata = 32'h0;
         endcase
      end
   end

endmodule

// File: rtl/unified_mem_responder.sv
// Single-port word array shared by fetch and load/store; clears itself after reset, then one access/cycle.
// Response registered one cycle after accept; data has priority, fetch waits via if_req_ready.
module unified_mem_responder
   import unified_mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_W      = 12
) (
   input  logic                    clk,
   input  logic                    rst,
   unified_mem_responder_if.slave  bus
);

   localparam int AW = $clog2(DEPTH_WORDS);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [AW-1:0]     r_cnt;
   logic [AW-1:0]     w_cnt_nxt;
   logic              w_init_we;

   logic [31:0]       r_mem [DEPTH_WORDS];

   logic              w_run;
   logic              w_d_acc;
   logic              w_i_acc;
   logic [ADDR_W-1:0] w_addr;
   logic [2:0]        w_f3;
   logic              w_we;
   logic              w_in_range;
   logic [AW-1:0]     w_idx;
   logic [31:0]       w_rword;
   logic [3:0]        w_be;
   logic [31:0]       w_wrep;
   logic [31:0]       w_rdata;
   logic              w_err;

   logic              r_if_rsp_valid;
   logic [31:0]       r_if_rdata;
   logic              r_if_rsp_err;
   logic              r_d_rsp_valid;
   logic [31:0]       r_d_rdata;
   logic              r_d_rsp_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_INIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_init_we   = 1'b0;
      case (r_state)
         ST_INIT: begin
            w_init_we = 1'b1;
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == AW'(DEPTH_WORDS - 1)) begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = '0;
            end
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   // Readies are masked by rst so nothing looks accepted on a reset edge.
   assign w_run            = (r_state == ST_RUN) && !rst;
   assign bus.d_req_ready  = w_run;
   assign bus.if_req_ready = w_run && !bus.d_req_valid;
   assign bus.init_done    = (r_state == ST_RUN);

   assign w_d_acc = w_run && bus.d_req_valid;
   assign w_i_acc = w_run && !bus.d_req_valid && bus.if_req_valid;

   assign w_addr     = bus.d_req_valid ? bus.d_addr : bus.if_addr;
   assign w_f3       = bus.d_req_valid ? bus.d_funct3 : F3_W;
   assign w_we       = bus.d_req_valid && bus.d_we;
   assign w_in_range = 32'(w_addr[ADDR_W-1:2]) < 32'(DEPTH_WORDS);
   assign w_idx      = w_addr[2 +: AW];
   assign w_rword    = r_mem[w_idx];

   mem_lane_align u_align (
      .i_we       (w_we),
      .i_funct3   (w_f3),
      .i_off      (w_addr[1:0]),
      .i_in_range (w_in_range),
      .i_wdata    (bus.d_wdata),
      .i_rword    (w_rword),
      .o_be       (w_be),
      .o_wdata    (w_wrep),
      .o_rdata    (w_rdata),
      .o_err      (w_err)
   );

   always_ff @(posedge clk) begin
      if (w_init_we) begin
         r_mem[r_cnt] <= 32'h0;
      end else if (w_d_acc) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wrep[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_if_rsp_valid <= 1'b0;
         r_if_rdata     <= 32'h0;
         r_if_rsp_err   <= 1'b0;
         r_d_rsp_valid  <= 1'b0;
         r_d_rdata      <= 32'h0;
         r_d_rsp_err    <= 1'b0;
      end else begin
         r_if_rsp_valid <= w_i_acc;
         r_d_rsp_valid  <= w_d_acc;
         if (w_i_acc) begin
            r_if_rdata   <= w_rdata;
            r_if_rsp_err <= w_err;
         end
         if (w_d_acc) begin
            r_d_rdata   <= w_rdata;
            r_d_rsp_err <= w_err;
         end
      end
   end

   assign bus.if_rsp_valid = r_if_rsp_valid;
   assign bus.if_rdata     = r_if_rdata;
   assign bus.if_rsp_err   = r_if_rsp_err;
   assign bus.d_rsp_valid  = r_d_rsp_valid;
   assign bus.d_rdata      = r_d_rdata;
   assign bus.d_rsp_err    = r_d_rsp_err;

endmodule
